// File: rtl/idelay_scan_pkg.sv
// Shared types and helpers for the IDELAYE2 tap-sweep eye scanner.
package idelay_scan_pkg;

  localparam int SCAN_TAP_W = 5;
  localparam int SCAN_NTAPS = 1 << SCAN_TAP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_JUDGE,
    S_CENTER,
    S_DONE
  } scan_state_e;

  // Window centre, rounding toward the window start; an empty window maps to tap 0.
  function automatic int unsigned eye_center(input int unsigned st, input int unsigned len);
    if (len == 0) return 0;
    return st + ((len - 1) >> 1);
  endfunction

endpackage

// File: rtl/idelay_tap_judge.sv
// Per-tap settle/sample timing and mismatch detection; pulses tap_valid during the judge cycle.
module idelay_tap_judge #(
  parameter int DATA_W      = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int SAMPLE_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              settle,
  input  logic              sample,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] train_pat,
  output logic              settle_last,
  output logic              sample_last,
  output logic              tap_valid,
  output logic              tap_good
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  logic [SET_W-1:0]       settle_cnt;
  logic [SAMPLE_LOG2-1:0] sample_cnt;
  logic                   err_flag;
  logic                   valid_q;

  assign settle_last = settle && (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign sample_last = sample && (&sample_cnt);
  assign tap_valid   = valid_q;
  assign tap_good    = valid_q && !err_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      err_flag   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      settle_cnt <= settle ? settle_cnt + SET_W'(1) : '0;
      sample_cnt <= sample ? sample_cnt + SAMPLE_LOG2'(1) : '0;
      valid_q    <= sample_last;
      // err_flag is cleared while settling so it only reflects this tap's samples.
      if (settle)
        err_flag <= 1'b0;
      else if (sample && (data_in != train_pat))
        err_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/idelay_eye_scan.sv
// IDELAYE2 tap-sweep trainer: finds the longest error-free tap window and loads its centre.
// Optional IDELAY_EYE_MAP_EN adds an eye_map output with one good/bad bit per tap.
module idelay_eye_scan
  import idelay_scan_pkg::*;
#(
  parameter int TAP_W       = SCAN_TAP_W,
  parameter int DATA_W      = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int SAMPLE_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     train_pat,
  output logic [TAP_W-1:0]      idelay_cnt,
  output logic                  idelay_ld,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
`ifdef IDELAY_EYE_MAP_EN
  output logic [(1<<TAP_W)-1:0] eye_map,
`endif
  output logic [TAP_W-1:0]      eye_start,
  output logic [TAP_W:0]        eye_len
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'((1 << TAP_W) - 1);

  scan_state_e      state, state_nxt;
  logic [TAP_W-1:0] tap, run_st, best_st, cnt_q, ctr;
  logic [TAP_W:0]   run_len, best_len, run_inc;
  logic             settle_last, sample_last, tap_valid, tap_good;

  idelay_tap_judge #(
    .DATA_W      (DATA_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .SAMPLE_LOG2 (SAMPLE_LOG2)
  ) u_judge (
    .clk         (clk),
    .rst         (rst),
    .settle      (state == S_SETTLE),
    .sample      (state == S_SAMPLE),
    .data_in     (data_in),
    .train_pat   (train_pat),
    .settle_last (settle_last),
    .sample_last (sample_last),
    .tap_valid   (tap_valid),
    .tap_good    (tap_good)
  );

  assign ctr     = TAP_W'(eye_center(32'(best_st), 32'(best_len)));
  assign run_inc = run_len + {{TAP_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    idelay_ld  = 1'b0;
    idelay_cnt = cnt_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy       = 1'b1;
        idelay_ld  = 1'b1;
        idelay_cnt = tap;
        state_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_last) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy = 1'b1;
        if (sample_last) state_nxt = S_JUDGE;
      end
      S_JUDGE: begin
        busy      = 1'b1;
        state_nxt = (tap == LAST_TAP) ? S_CENTER : S_LOAD;
      end
      S_CENTER: begin
        busy       = 1'b1;
        idelay_ld  = 1'b1;
        idelay_cnt = ctr;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef IDELAY_EYE_MAP_EN
  logic [(1<<TAP_W)-1:0] map_q;
  assign eye_map = map_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tap       <= '0;
      run_len   <= '0;
      run_st    <= '0;
      best_len  <= '0;
      best_st   <= '0;
      cnt_q     <= '0;
      fail      <= 1'b0;
      eye_start <= '0;
      eye_len   <= '0;
`ifdef IDELAY_EYE_MAP_EN
      map_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          tap      <= '0;
          run_len  <= '0;
          run_st   <= '0;
          best_len <= '0;
          best_st  <= '0;
          fail     <= 1'b0;
`ifdef IDELAY_EYE_MAP_EN
          map_q    <= '0;
`endif
        end
        S_LOAD: cnt_q <= tap;
        S_JUDGE: begin
          if (tap_valid) begin
            if (tap_good) begin
              run_len <= run_inc;
              if (run_len == '0) run_st <= tap;
              // Strictly greater: on equal length the earlier window is kept.
              if (run_inc > best_len) begin
                best_len <= run_inc;
                best_st  <= (run_len == '0) ? tap : run_st;
              end
            end else begin
              run_len <= '0;
            end
`ifdef IDELAY_EYE_MAP_EN
            map_q[tap] <= tap_good;
`endif
          end
          if (tap != LAST_TAP) tap <= tap + TAP_W'(1);
        end
        S_CENTER: begin
          cnt_q     <= ctr;
          fail      <= (best_len == '0);
          eye_start <= best_st;
          eye_len   <= best_len;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_eye_scan.sv
// Directed bench for idelay_eye_scan: table of eye masks plus mid-scan reset and busy-start sequences.
module tb_idelay_eye_scan;

  localparam int TAP_W    = 5;
  localparam int NTAPS    = 32;
  localparam int SETTLE   = 4;
  localparam int SLOG2    = 3;
  localparam int PER_TAP  = 1 + SETTLE + (1 << SLOG2) + 1;
  localparam int SCAN_CYC = NTAPS * PER_TAP + 2;
  localparam int INJ_OFS  = 1 + SETTLE + (1 << SLOG2) - 1;

  logic             clk, rst, start;
  logic [7:0]       data_in, train_pat;
  logic [TAP_W-1:0] idelay_cnt, eye_start;
  logic [TAP_W:0]   eye_len;
  logic             idelay_ld, busy, done, fail;
`ifdef IDELAY_EYE_MAP_EN
  logic [NTAPS-1:0] eye_map;
`endif

  idelay_eye_scan #(
    .TAP_W(TAP_W), .DATA_W(8), .SETTLE_CYC(SETTLE), .SAMPLE_LOG2(SLOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .train_pat  (train_pat),
    .idelay_cnt (idelay_cnt),
    .idelay_ld  (idelay_ld),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
`ifdef IDELAY_EYE_MAP_EN
    .eye_map    (eye_map),
`endif
    .eye_start  (eye_start),
    .eye_len    (eye_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] good;
    logic [7:0]  pat;
    logic [4:0]  e_start;
    logic [5:0]  e_len;
    logic [4:0]  e_cnt;
    logic        e_fail;
    logic        inj;
    int          restart_at;
    logic [31:0] e_map;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] good;
  logic        inj_en;
  logic [4:0]  ld_tap, last_ld_cnt;
  int          since_ld, ld_count;
  int          n_chk, n_fail;

  // Delay-line model: the word is clean only at good taps; optional one-cycle glitch at tap 12.
  always @(negedge clk) begin
    if (idelay_ld) begin
      ld_tap      = idelay_cnt;
      last_ld_cnt = idelay_cnt;
      since_ld    = 0;
      ld_count    = ld_count + 1;
    end else begin
      since_ld = since_ld + 1;
    end
    if (good[idelay_cnt] && !(inj_en && ld_tap == 5'd12 && since_ld == INJ_OFS))
      data_in = train_pat;
    else
      data_in = ~train_pat;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int base;
    good      = v.good;
    inj_en    = v.inj;
    train_pat = v.pat;
    base      = ld_count;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    check($sformatf("v%0d busy_rise", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d fail_cleared", idx), 32'(fail), 32'd0);
    while (!done && lat < SCAN_CYC + 50) begin
      @(negedge clk);
      lat++;
      start = (lat == v.restart_at);
    end
    start = 1'b0;
    check($sformatf("v%0d done_seen", idx), 32'(done), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(SCAN_CYC));
    check($sformatf("v%0d busy_fall", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d eye_start", idx), 32'(eye_start), 32'(v.e_start));
    check($sformatf("v%0d eye_len", idx), 32'(eye_len), 32'(v.e_len));
    check($sformatf("v%0d fail", idx), 32'(fail), 32'(v.e_fail));
    check($sformatf("v%0d final_cnt", idx), 32'(idelay_cnt), 32'(v.e_cnt));
    check($sformatf("v%0d center_ld_cnt", idx), 32'(last_ld_cnt), 32'(v.e_cnt));
    check($sformatf("v%0d ld_pulses", idx), 32'(ld_count - base), 32'(NTAPS + 1));
`ifdef IDELAY_EYE_MAP_EN
    check($sformatf("v%0d eye_map", idx), eye_map, v.e_map);
`endif
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    check($sformatf("v%0d cnt_hold", idx), 32'(idelay_cnt), 32'(v.e_cnt));
    check($sformatf("v%0d len_hold", idx), 32'(eye_len), 32'(v.e_len));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " idelay_cnt"}, 32'(idelay_cnt), 32'd0);
    check({tag, " idelay_ld"}, 32'(idelay_ld), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " fail"}, 32'(fail), 32'd0);
    check({tag, " eye_start"}, 32'(eye_start), 32'd0);
    check({tag, " eye_len"}, 32'(eye_len), 32'd0);
`ifdef IDELAY_EYE_MAP_EN
    check({tag, " eye_map"}, eye_map, 32'd0);
`endif
  endtask

  initial begin
    int n;
    int base;
    int activity;
    n_chk = 0; n_fail = 0; ld_count = 0; since_ld = 0; ld_tap = 5'd0; last_ld_cnt = 5'd0;
    rst = 1'b1; start = 1'b0; train_pat = 8'hA5; good = 32'h0; inj_en = 1'b0;

    vecs[0] = '{32'h000FFC00, 8'hA5, 5'd10, 6'd10, 5'd14, 1'b0, 1'b0, 0,   32'h000FFC00};
    vecs[1] = '{32'h0FF00078, 8'h3C, 5'd20, 6'd8,  5'd23, 1'b0, 1'b0, 0,   32'h0FF00078};
    vecs[2] = '{32'h00F0003C, 8'hC3, 5'd2,  6'd4,  5'd3,  1'b0, 1'b0, 0,   32'h00F0003C};
    vecs[3] = '{32'hFFFFFFFF, 8'h81, 5'd0,  6'd32, 5'd15, 1'b0, 1'b0, 0,   32'hFFFFFFFF};
    vecs[4] = '{32'h00000000, 8'h7E, 5'd0,  6'd0,  5'd0,  1'b1, 1'b0, 0,   32'h00000000};
    vecs[5] = '{32'h0001FE00, 8'h5A, 5'd13, 6'd4,  5'd14, 1'b0, 1'b1, 0,   32'h0001EE00};
    vecs[6] = '{32'h000FFC00, 8'hA5, 5'd10, 6'd10, 5'd14, 1'b0, 1'b0, 100, 32'h000FFC00};

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Abort in the sampling phase of tap 7.
    good = 32'h000FFC00; inj_en = 1'b0; train_pat = 8'hA5;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(idelay_ld && idelay_cnt == 5'd7) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst tap7_reached", 32'(idelay_ld && idelay_cnt == 5'd7), 32'd1);
    repeat (8) @(negedge clk);
    check("rst in_scan", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    base = ld_count;
    activity = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy || done || idelay_ld) activity++;
    end
    check("midrst no_ld", 32'(ld_count - base), 32'd0);
    check("midrst quiet", 32'(activity), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
